// File: rtl/bit_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// bit_serial_adder_ctrl
//
// Sequencer and bit-serial full adder that sits beside the Memory_array
// compute column. It walks the stored operand A one row at a time, LSB first.
// Each row is read through ToAdder, summed with the latched parallel operand
// B (inverted for subtraction), and the sum bit is written back into the same
// row. Every bit takes a READ cycle and then a WRITE cycle. When the last
// write is done, completion, carry-out and signed overflow go to the host.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle request, only honoured in IDLE
//   sub        in   0: A+B, 1: A-B (latched with start)
//   OperandB   in   parallel operand B (latched with start)
//   ToAdder    in   bit read from the row selected by RWL
//   RWL        out  read wordline, one-hot or zero
//   WWL        out  write wordline, one-hot or zero
//   FromAdder  out  sum bit written into the row selected by WWL
//   busy       out  high while reading/writing the array
//   done       out  one-cycle pulse after the last write
//   Result     out  copy of the written sum bits, held until the next start
//   CarryOut   out  carry out of the MSB (for sub, 1 = no borrow)
//   Overflow   out  signed overflow of the operation
// ---------------------------------------------------------------------------
module bit_serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             ToAdder,
    output logic [WIDTH-1:0] RWL,
    output logic [WIDTH-1:0] WWL,
    output logic             FromAdder,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             CarryOut,
    output logic             Overflow
);

    // Width of the bit index; a one-row array still needs a one-bit index.
    localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [JW-1:0] LAST_BIT = JW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [JW-1:0]    bit_idx;
    logic             carry;
    logic             carry_into_msb;
    logic [WIDTH-1:0] b_latched;

    logic             sum_now;
    logic             carry_now;

    // Builds the one-hot wordline pattern for a given row index.
    function automatic logic [WIDTH-1:0] row_select(input logic [JW-1:0] idx);
        logic [WIDTH-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

    // Full-adder slice for the row that is being read. The array read path is
    // combinational inside the READ cycle. This slice only feeds registers, so
    // ToAdder never reaches an output without passing through a flop first.
    always_comb begin
        sum_now   = ToAdder ^ b_latched[bit_idx] ^ carry;
        carry_now = (ToAdder & b_latched[bit_idx])
                  | (ToAdder & carry)
                  | (b_latched[bit_idx] & carry);
    end

    // Main sequencer. Every output is a flop, so the wordlines and write data
    // for a cycle are all decided at the edge that enters that cycle.
    // FromAdder also serves as the sum register. It loads the new sum bit at
    // the edge that enters WRITE and drops back to 0 when WRITE is left, so it
    // stays low outside WRITE. A start that arrives in READ, WRITE or DONE
    // falls through the case arms with no effect and is never remembered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            bit_idx        <= '0;
            carry          <= 1'b0;
            carry_into_msb <= 1'b0;
            b_latched      <= '0;
            RWL            <= '0;
            WWL            <= '0;
            FromAdder      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            Result         <= '0;
            CarryOut       <= 1'b0;
            Overflow       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    RWL       <= '0;
                    WWL       <= '0;
                    FromAdder <= 1'b0;
                    busy      <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1. The +1 comes in through
                        // the initial carry.
                        b_latched <= sub ? ~OperandB : OperandB;
                        carry     <= sub;
                        bit_idx   <= '0;
                        Result    <= '0;
                        CarryOut  <= 1'b0;
                        Overflow  <= 1'b0;
                        RWL       <= row_select('0);
                        busy      <= 1'b1;
                        state     <= ST_READ;
                    end
                end

                ST_READ: begin
                    FromAdder       <= sum_now;
                    Result[bit_idx] <= sum_now;
                    carry           <= carry_now;
                    // The carry entering the MSB is the old carry at the last
                    // row. It is needed later to detect signed overflow.
                    if (bit_idx == LAST_BIT) begin
                        carry_into_msb <= carry;
                    end
                    RWL   <= '0;
                    WWL   <= row_select(bit_idx);
                    state <= ST_WRITE;
                end

                ST_WRITE: begin
                    WWL       <= '0;
                    FromAdder <= 1'b0;
                    if (bit_idx == LAST_BIT) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        CarryOut <= carry;
                        Overflow <= carry_into_msb ^ carry;
                        state    <= ST_DONE;
                    end else begin
                        bit_idx <= bit_idx + JW'(1);
                        RWL     <= row_select(bit_idx + JW'(1));
                        state   <= ST_READ;
                    end
                end

                ST_DONE: begin
                    RWL       <= '0;
                    WWL       <= '0;
                    FromAdder <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end

                default: begin
                    RWL       <= '0;
                    WWL       <= '0;
                    FromAdder <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_adder_ctrl
//
// Testbench for bit_serial_adder_ctrl. It contains a small model of the
// memory column, and the reference results come from plain integer
// arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_bit_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] OperandB;
    logic       ToAdder;
    logic [7:0] RWL;
    logic [7:0] WWL;
    logic       FromAdder;
    logic       busy;
    logic       done;
    logic [7:0] Result;
    logic       CarryOut;
    logic       Overflow;

    int vectors;
    int miscompares;

    // Memory column model: row i holds bit i of the stored operand.
    logic [7:0] mem_rows;
    logic       preload_en;
    logic [7:0] preload_val;

    bit_serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .OperandB  (OperandB),
        .ToAdder   (ToAdder),
        .RWL       (RWL),
        .WWL       (WWL),
        .FromAdder (FromAdder),
        .busy      (busy),
        .done      (done),
        .Result    (Result),
        .CarryOut  (CarryOut),
        .Overflow  (Overflow)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The array read is combinational from whichever row the read wordline selects.
    assign ToAdder = |(RWL & mem_rows);

    // Array writes take effect at the clock edge that ends the write cycle.
    // The preload port lets the bench place operand A before an operation starts.
    always @(posedge clk) begin
        if (preload_en) begin
            mem_rows <= preload_val;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (WWL[i]) mem_rows[i] <= FromAdder;
            end
        end
    end

    // Reference model: plain 8-bit arithmetic plus a signed-range check.
    function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                                   output logic [7:0] r, output logic c, output logic v);
        int ai, bi, sa, sb, tot, stot;
        ai = int'(a);
        bi = int'(b);
        sa = (ai >= 128) ? ai - 256 : ai;
        sb = (bi >= 128) ? bi - 256 : bi;
        if (!s) begin
            tot  = ai + bi;
            stot = sa + sb;
            c    = (tot > 255);
        end else begin
            tot  = ai - bi;
            stot = sa - sb;
            c    = (ai >= bi);
        end
        r = 8'(tot & 255);
        v = (stot > 127) || (stot < -128);
    endfunction

    // Runs one operation from a negedge-aligned point. It records what the DUT
    // did and does not judge it. seq_err counts cycles whose wordlines, write
    // data, busy or done did not match the expected schedule.
    task automatic drive_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                            input int extra_at,
                            output int done_at, output int seq_err,
                            output logic [7:0] res, output logic cout, output logic ovf,
                            output logic [7:0] res_late, output logic [7:0] rows_after);
        logic [7:0] er, e_rwl, e_wwl;
        logic       ec, ev, e_from, e_busy, e_done;
        ref_op(a, b, s, er, ec, ev);
        preload_val = a;
        preload_en  = 1'b1;
        OperandB    = b;
        sub         = s;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        preload_en = 1'b0;
        OperandB   = 8'($urandom);
        sub        = 1'($urandom);
        done_at    = -1;
        seq_err    = 0;
        res        = 8'h00;
        cout       = 1'b0;
        ovf        = 1'b0;
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            e_rwl  = 8'h00;
            e_wwl  = 8'h00;
            e_from = 1'b0;
            e_busy = 1'b0;
            e_done = 1'b0;
            if (c < 16) begin
                e_busy = 1'b1;
                if (c % 2 == 0) begin
                    e_rwl = 8'd1 << (c / 2);
                end else begin
                    e_wwl  = 8'd1 << (c / 2);
                    e_from = er[c / 2];
                end
            end else if (c == 16) begin
                e_done = 1'b1;
            end
            if (RWL !== e_rwl || WWL !== e_wwl || FromAdder !== e_from ||
                busy !== e_busy || done !== e_done) begin
                seq_err++;
            end
            if (done === 1'b1 && done_at < 0) done_at = c;
            if (c == 16) begin
                res  = Result;
                cout = CarryOut;
                ovf  = Overflow;
            end
            if (c == extra_at) begin
                start    = 1'b1;
                OperandB = ~b;
                sub      = ~s;
            end else begin
                start = 1'b0;
            end
        end
        res_late   = Result;
        rows_after = mem_rows;
    endtask

    // Every output must read 0 while reset is held and right after it is released.
    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sub = 1'b0;
        OperandB = 8'h00;
        preload_en = 1'b0;
        preload_val = 8'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if ({RWL, WWL, FromAdder, busy, done, Result, CarryOut, Overflow} !== 29'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: outputs=%h required 0",
                     {RWL, WWL, FromAdder, busy, done, Result, CarryOut, Overflow});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({RWL, WWL, FromAdder, busy, done, Result, CarryOut, Overflow} !== 29'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: outputs=%h required 0",
                     {RWL, WWL, FromAdder, busy, done, Result, CarryOut, Overflow});
        end
    endtask

    // Directed corner cases: plain add, carry wrap, borrow, signed overflow.
    task automatic test_directed();
        logic [7:0] ta [6] = '{8'h55, 8'hFF, 8'h10, 8'h00, 8'h7F, 8'h80};
        logic [7:0] tb [6] = '{8'h0F, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        logic       ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            int da, se;
            logic [7:0] r, rl, rows, er;
            logic co, ov, ec, ev;
            ref_op(ta[i], tb[i], ts[i], er, ec, ev);
            drive_op(ta[i], tb[i], ts[i], -1, da, se, r, co, ov, rl, rows);
            vectors++;
            if ({r, co, ov} !== {er, ec, ev}) begin
                miscompares++;
                $display("[TB] FAIL directed_%0d result: got %h/%b/%b want %h/%b/%b",
                         i, r, co, ov, er, ec, ev);
            end
            vectors++;
            if (rows !== er) begin
                miscompares++;
                $display("[TB] FAIL directed_%0d rows: got %h want %h", i, rows, er);
            end
            vectors++;
            if (da !== 16 || se !== 0) begin
                miscompares++;
                $display("[TB] FAIL directed_%0d timing: done_at=%0d seq_err=%0d want 16/0",
                         i, da, se);
            end
        end
    endtask

    // A second start pulsed mid-operation must be ignored and must not queue.
    task automatic test_ignored_start();
        int da, se, extra_busy;
        logic [7:0] r, rl, rows;
        logic co, ov;
        drive_op(8'h55, 8'h0F, 1'b0, 4, da, se, r, co, ov, rl, rows);
        vectors++;
        if (r !== 8'h64 || rl !== 8'h64 || rows !== 8'h64 || co !== 1'b0 || ov !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ignored_start result: got %h late %h rows %h c=%b v=%b want 64",
                     r, rl, rows, co, ov);
        end
        vectors++;
        if (da !== 16 || se !== 0) begin
            miscompares++;
            $display("[TB] FAIL ignored_start timing: done_at=%0d seq_err=%0d want 16/0", da, se);
        end
        extra_busy = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || RWL !== 8'h00) extra_busy++;
        end
        vectors++;
        if (extra_busy !== 0) begin
            miscompares++;
            $display("[TB] FAIL ignored_start queued: busy cycles=%0d want 0", extra_busy);
        end
    endtask

    // Random operands and operations against the arithmetic model.
    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int da, se;
            logic [7:0] a, b, r, rl, rows, er;
            logic s, co, ov, ec, ev;
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            ref_op(a, b, s, er, ec, ev);
            drive_op(a, b, s, -1, da, se, r, co, ov, rl, rows);
            vectors++;
            if ({r, co, ov, rows} !== {er, ec, ev, er} || da !== 16 || se !== 0) begin
                miscompares++;
                $display("[TB] FAIL random_%0d a=%h b=%h sub=%b: got %h/%b/%b rows %h done_at=%0d seq_err=%0d want %h/%b/%b",
                         i, a, b, s, r, co, ov, rows, da, se, er, ec, ev);
            end
        end
    endtask

    // A start raised in the first IDLE cycle after done must be accepted.
    task automatic test_back_to_back();
        int da1, se1, da2, se2;
        logic [7:0] r1, rl1, rows1, r2, rl2, rows2, e1, e2;
        logic co1, ov1, co2, ov2, ec1, ev1, ec2, ev2;
        ref_op(8'hA3, 8'h5C, 1'b0, e1, ec1, ev1);
        ref_op(8'h3C, 8'hC5, 1'b1, e2, ec2, ev2);
        drive_op(8'hA3, 8'h5C, 1'b0, -1, da1, se1, r1, co1, ov1, rl1, rows1);
        drive_op(8'h3C, 8'hC5, 1'b1, -1, da2, se2, r2, co2, ov2, rl2, rows2);
        vectors++;
        if ({r1, co1, ov1} !== {e1, ec1, ev1} || da1 !== 16 || se1 !== 0) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_first: got %h/%b/%b done_at=%0d seq_err=%0d want %h/%b/%b",
                     r1, co1, ov1, da1, se1, e1, ec1, ev1);
        end
        vectors++;
        if ({r2, co2, ov2, rows2} !== {e2, ec2, ev2, e2} || da2 !== 16 || se2 !== 0) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_second: got %h/%b/%b rows %h done_at=%0d seq_err=%0d want %h/%b/%b",
                     r2, co2, ov2, rows2, da2, se2, e2, ec2, ev2);
        end
    endtask

    // Reset asserted during READ(3) must stop everything at once and leave the
    // array partly rewritten. A fresh operation afterwards must run normally.
    task automatic test_reset_mid();
        logic [7:0] a, b, er, exp_rows, r, rl, rows;
        logic ec, ev, co, ov;
        int saw_done, da, se;
        a = 8'hC6;
        b = 8'h3B;
        ref_op(a, b, 1'b0, er, ec, ev);
        exp_rows = {a[7:3], er[2:0]};
        preload_val = a;
        preload_en  = 1'b1;
        OperandB    = b;
        sub         = 1'b0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        preload_en = 1'b0;
        repeat (7) @(negedge clk);
        vectors++;
        if (RWL !== 8'h08) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_setup: RWL=%h want 08", RWL);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (RWL !== 8'h00 || WWL !== 8'h00 || busy !== 1'b0 || FromAdder !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_async: RWL=%h WWL=%h busy=%b from=%b want 0",
                     RWL, WWL, busy, FromAdder);
        end
        saw_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done++;
        end
        vectors++;
        if (saw_done !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_done: done cycles=%0d want 0", saw_done);
        end
        vectors++;
        if (mem_rows !== exp_rows) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_rows: got %h want %h", mem_rows, exp_rows);
        end
        ref_op(8'h21, 8'h13, 1'b1, er, ec, ev);
        drive_op(8'h21, 8'h13, 1'b1, -1, da, se, r, co, ov, rl, rows);
        vectors++;
        if ({r, co, ov, rows} !== {er, ec, ev, er} || da !== 16 || se !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_recover: got %h/%b/%b rows %h done_at=%0d seq_err=%0d want %h/%b/%b",
                     r, co, ov, rows, da, se, er, ec, ev);
        end
    endtask

    // Run the scenarios in order, then print the summary line.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_ignored_start();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
